prbs_checker: RTL and testbench

Self-synchronising PRBS checker that receives a serial bit stream produced by the project's Fibonacci LFSR generator and verifies it bit by bit. It seeds its own LFSR copy from the incoming bits, confirms lock over a run of correctly predicted bits, then counts bit errors and detects loss of synchronisation. It sits at the receiving end of the LFSR link in the top-level user project, next to the generator. Its lock and error outputs go to the dedicated outputs for bring-up.

---
 rtl/prbs_if.sv | 23 ++
 rtl/prbs_checker.sv | 138 +++++++++++++
 tb/tb_prbs_checker.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/prbs_if.sv
// Serial PRBS link bundle between a bit source and the checker.
// The source drives data/valid/clear; the checker returns lock and error status.
interface prbs_if #(
   parameter int ERR_W = 16
);
   logic             bit_in;
   logic             bit_valid;
   logic             clear;
   logic             locked;
   logic             err_pulse;
   logic             lost_sync;
   logic [ERR_W-1:0] err_count;

   modport master (
      output bit_in, bit_valid, clear,
      input  locked, err_pulse, lost_sync, err_count
   );

   modport slave (
      input  bit_in, bit_valid, clear,
      output locked, err_pulse, lost_sync, err_count
   );
endinterface

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker: seeds a local Fibonacci LFSR from the
// stream, verifies a run of predictions, then flywheels and counts errors.
module prbs_checker #(
   parameter int               WIDTH      = 8,
   parameter logic [WIDTH-1:0] TAPS       = 8'hB8,
   parameter int               LOCK_COUNT = 16,
   parameter int               LOSS_COUNT = 4,
   parameter int               ERR_W      = 16
) (
   input logic    clk,
   input logic    rst,
   prbs_if.slave  bus
);
   localparam int SW = $clog2(WIDTH + 1);
   localparam int MW = $clog2(LOCK_COUNT + 1);
   localparam int LW = $clog2(LOSS_COUNT + 1);

   typedef enum logic [1:0] {
      SEED,
      VERIFY,
      LOCKED
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [SW-1:0]    seed_cnt_q, seed_cnt_d;
   logic [MW-1:0]    match_cnt_q, match_cnt_d;
   logic [LW-1:0]    miss_cnt_q, miss_cnt_d;
   logic [ERR_W-1:0] err_count_q, err_count_d;
   logic             err_pulse_q, err_pulse_d;
   logic             lost_sync_q, lost_sync_d;

   logic             pred;
   logic [WIDTH-1:0] shift_in;
   logic             hit;

   assign pred     = ^(r_q & TAPS);
   assign shift_in = {r_q[WIDTH-2:0], bus.bit_in};
   assign hit      = (bus.bit_in == pred);

   always_comb begin
      state_d     = state_q;
      r_d         = r_q;
      seed_cnt_d  = seed_cnt_q;
      match_cnt_d = match_cnt_q;
      miss_cnt_d  = miss_cnt_q;
      err_count_d = err_count_q;
      err_pulse_d = 1'b0;
      lost_sync_d = 1'b0;

      if (bus.clear)
         err_count_d = '0;

      if (bus.bit_valid) begin
         unique case (state_q)
            SEED: begin
               r_d = shift_in;
               if (seed_cnt_q == SW'(WIDTH - 1)) begin
                  seed_cnt_d = '0;
                  if (shift_in != '0) begin
                     state_d     = VERIFY;
                     match_cnt_d = '0;
                  end
               end else begin
                  seed_cnt_d = seed_cnt_q + 1'b1;
               end
            end
            VERIFY: begin
               if (hit) begin
                  r_d = shift_in;
                  if (match_cnt_q == MW'(LOCK_COUNT - 1)) begin
                     state_d     = LOCKED;
                     match_cnt_d = '0;
                  end else begin
                     match_cnt_d = match_cnt_q + 1'b1;
                  end
               end else begin
                  state_d     = SEED;
                  seed_cnt_d  = '0;
                  match_cnt_d = '0;
               end
            end
            LOCKED: begin
               // Flywheel: feed back our own prediction, not the received bit.
               r_d = {r_q[WIDTH-2:0], pred};
               if (!hit) begin
                  err_pulse_d = 1'b1;
                  if (bus.clear)
                     err_count_d = ERR_W'(1);
                  else if (err_count_q != {ERR_W{1'b1}})
                     err_count_d = err_count_q + 1'b1;
                  if (miss_cnt_q == LW'(LOSS_COUNT - 1)) begin
                     lost_sync_d = 1'b1;
                     state_d     = SEED;
                     seed_cnt_d  = '0;
                     match_cnt_d = '0;
                     miss_cnt_d  = '0;
                  end else begin
                     miss_cnt_d = miss_cnt_q + 1'b1;
                  end
               end else begin
                  miss_cnt_d = '0;
               end
            end
            default: begin
               state_d = SEED;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= SEED;
         r_q         <= '0;
         seed_cnt_q  <= '0;
         match_cnt_q <= '0;
         miss_cnt_q  <= '0;
         err_count_q <= '0;
         err_pulse_q <= 1'b0;
         lost_sync_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         r_q         <= r_d;
         seed_cnt_q  <= seed_cnt_d;
         match_cnt_q <= match_cnt_d;
         miss_cnt_q  <= miss_cnt_d;
         err_count_q <= err_count_d;
         err_pulse_q <= err_pulse_d;
         lost_sync_q <= lost_sync_d;
      end
   end

   assign bus.locked    = (state_q == LOCKED);
   assign bus.err_pulse = err_pulse_q;
   assign bus.lost_sync = lost_sync_q;
   assign bus.err_count = err_count_q;
endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboard bench for prbs_checker: stimulus pushes expected outputs,
// a monitor pops and compares them one cycle later.
module tb_prbs_checker;
   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   prbs_if #(.ERR_W(16)) bus ();

   prbs_checker dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      string tag;
      logic  lk;
      logic  pu;
      logic  ls;
      int    cnt;
   } exp_t;

   exp_t       sb[$];
   exp_t       e;
   int         checks = 0;
   int         errors = 0;
   string      tag;
   int         ecnt;
   logic [7:0] g;
   logic [7:0] h;
   logic       b;

   task automatic check(input string t, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d", t, got, exp);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check({e.tag, ".locked"}, 32'(bus.locked), 32'(e.lk));
         check({e.tag, ".err_pulse"}, 32'(bus.err_pulse), 32'(e.pu));
         check({e.tag, ".lost_sync"}, 32'(bus.lost_sync), 32'(e.ls));
         check({e.tag, ".err_count"}, 32'(bus.err_count), e.cnt);
      end
   end

   task automatic drive(input logic bi, input logic v, input logic clr,
                        input logic lk, input logic pu, input logic ls,
                        input int cnt);
      exp_t x;
      @(negedge clk);
      bus.bit_in    = bi;
      bus.bit_valid = v;
      bus.clear     = clr;
      x.tag = tag;
      x.lk  = lk;
      x.pu  = pu;
      x.ls  = ls;
      x.cnt = cnt;
      sb.push_back(x);
   endtask

   // Reference generator: x^8+x^6+x^5+x^4+1, new bit is the output.
   task automatic gen(output logic o);
      o = g[7] ^ g[5] ^ g[4] ^ g[3];
      g = {g[6:0], o};
   endtask

   task automatic do_reset();
      @(negedge clk);
      bus.bit_valid = 1'b0;
      bus.clear     = 1'b0;
      bus.bit_in    = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst  = 1'b0;
      ecnt = 0;
      g    = 8'h01;
   endtask

   task automatic acquire();
      logic o;
      for (int i = 1; i <= 24; i++) begin
         gen(o);
         drive(o, 1'b1, 1'b0, i == 24, 1'b0, 1'b0, ecnt);
      end
   endtask

   task automatic clean(input int n);
      logic o;
      for (int i = 0; i < n; i++) begin
         gen(o);
         drive(o, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ecnt);
      end
   endtask

   task automatic bad(input logic lk, input logic ls);
      logic o;
      gen(o);
      ecnt++;
      drive(~o, 1'b1, 1'b0, lk, 1'b1, ls, ecnt);
   endtask

   initial begin
      rst           = 1'b1;
      bus.bit_in    = 1'b0;
      bus.bit_valid = 1'b0;
      bus.clear     = 1'b0;
      g             = 8'h01;
      ecnt          = 0;
      #12;
      check("reset.locked", 32'(bus.locked), 0);
      check("reset.err_pulse", 32'(bus.err_pulse), 0);
      check("reset.lost_sync", 32'(bus.lost_sync), 0);
      check("reset.err_count", 32'(bus.err_count), 0);
      @(negedge clk);
      rst = 1'b0;

      tag = "acq";
      for (int i = 1; i <= 1000; i++) begin
         gen(b);
         drive(b, 1'b1, 1'b0, i >= 24, 1'b0, 1'b0, 0);
      end

      tag = "single";
      clean(39);
      bad(1'b1, 1'b0);
      clean(500);

      do_reset();
      tag = "loss";
      acquire();
      bad(1'b1, 1'b0);
      bad(1'b1, 1'b0);
      bad(1'b1, 1'b0);
      bad(1'b0, 1'b1);
      tag = "relock";
      acquire();

      do_reset();
      tag = "burst";
      acquire();
      repeat (3) bad(1'b1, 1'b0);
      clean(1);
      repeat (3) bad(1'b1, 1'b0);
      clean(5);

      do_reset();
      tag = "zeros";
      repeat (200) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);

      do_reset();
      tag = "random";
      h = '0;
      for (int i = 1; i <= 2000; i++) begin
         // Every 8th bit breaks the recurrence so no 16-bit run can match.
         if (i % 8 == 0)
            b = ~(h[7] ^ h[5] ^ h[4] ^ h[3]);
         else
            b = 1'($urandom_range(0, 1));
         h = {h[6:0], b};
         drive(b, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      end

      do_reset();
      tag = "gaps";
      for (int k = 1; k <= 24; k++) begin
         gen(b);
         drive(b, 1'b1, 1'b0, k == 24, 1'b0, 1'b0, 0);
         repeat (2)
            drive(1'($urandom_range(0, 1)), 1'b0, 1'b0, k == 24,
                  1'b0, 1'b0, 0);
      end

      tag = "clear";
      repeat (5) begin
         bad(1'b1, 1'b0);
         clean(1);
      end
      gen(b);
      ecnt = 1;
      drive(~b, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1);
      gen(b);
      ecnt = 0;
      drive(b, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
      clean(3);

      do_reset();
      tag = "rstmid";
      acquire();
      repeat (3) begin
         bad(1'b1, 1'b0);
         clean(1);
      end
      @(negedge clk);
      bus.bit_valid = 1'b0;
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("rstmid.locked", 32'(bus.locked), 0);
      check("rstmid.err_pulse", 32'(bus.err_pulse), 0);
      check("rstmid.lost_sync", 32'(bus.lost_sync), 0);
      check("rstmid.err_count", 32'(bus.err_count), 0);
      @(negedge clk);
      rst  = 1'b0;
      ecnt = 0;
      tag  = "rstrelock";
      acquire();

      @(negedge clk);
      bus.bit_valid = 1'b0;
      @(negedge clk);
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard left %0d entries", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
